// File: rtl/tile_result_writer.sv
// Packs 16-bit per-pixel iteration counts into 32-bit word writes through a show-ahead command FIFO.
// Optional macro TILE_WRITER_TIMEOUT_EN: evicts a lone held halfword after 15 idle HOLD cycles.
module tile_result_writer #(
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH_BITS = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] in_addr,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        flush,
   output logic [31:0] mem_address,
   output logic [31:0] mem_writedata,
   output logic [3:0]  mem_byteenable,
   output logic        mem_write,
   input  logic        mem_waitrequest,
   output logic        busy,
   output logic [15:0] writes_done
);

   localparam int unsigned PW    = FIFO_DEPTH_BITS;
   localparam int unsigned CW    = FIFO_DEPTH_BITS + 1;
   localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_BITS;

   typedef struct packed {
      logic [31:0] address;
      logic [31:0] data;
      logic [3:0]  be;
   } wr_cmd_t;

   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t      state, state_next;
   logic [31:0] held_addr;
   logic [15:0] held_data;
   logic        flush_pend;
   logic        timeout_hit;

   wr_cmd_t     fifo_mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;

   logic        fifo_full, fifo_empty, deq, can_enq;
   logic        match, mismatch, accept, evict_req, hold_load, enq;
   wr_cmd_t     enq_cmd, head;

   function automatic logic [31:0] word_addr(input logic [31:0] p);
      return BASE_ADDR + {p[31:1], 2'b00};
   endfunction

   // FIFO status and handshake terms
   always_comb begin
      fifo_full  = (count == CW'(DEPTH));
      fifo_empty = (count == '0);
      deq        = !fifo_empty && !mem_waitrequest;
      can_enq    = !fifo_full || deq;
      match      = in_valid && (in_addr == held_addr + 32'd1);
      mismatch   = (state == HOLD) && in_valid && !match;
      in_ready   = !fifo_full && !mismatch;
      accept     = in_valid && in_ready;
      evict_req  = (state == HOLD) && !accept &&
                   (mismatch || flush || flush_pend || timeout_hit);
   end

   // Pack FSM next-state and enqueue decision
   always_comb begin
      state_next = state;
      enq        = 1'b0;
      enq_cmd    = '0;
      hold_load  = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               if (in_addr[0]) begin
                  enq     = 1'b1;
                  enq_cmd = '{address: word_addr(in_addr),
                              data:    {in_data, 16'h0000},
                              be:      4'b1100};
               end else begin
                  hold_load  = 1'b1;
                  state_next = HOLD;
               end
            end
         end
         HOLD: begin
            if (accept) begin
               enq        = 1'b1;
               enq_cmd    = '{address: word_addr(held_addr),
                              data:    {in_data, held_data},
                              be:      4'b1111};
               state_next = EMPTY;
            end else if (evict_req && can_enq) begin
               enq        = 1'b1;
               enq_cmd    = '{address: word_addr(held_addr),
                              data:    {16'h0000, held_data},
                              be:      4'b0011};
               state_next = EMPTY;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= EMPTY;
         held_addr  <= '0;
         held_data  <= '0;
         flush_pend <= 1'b0;
      end else begin
         state      <= state_next;
         // A flush that cannot be serviced for lack of FIFO space is remembered
         flush_pend <= (state == HOLD) && (state_next == HOLD) && (flush || flush_pend);
         if (hold_load) begin
            held_addr <= in_addr;
            held_data <= in_data;
         end
      end
   end

`ifdef TILE_WRITER_TIMEOUT_EN
   logic [3:0] timeout_cnt;

   always_ff @(posedge clock) begin
      if (reset || hold_load) begin
         timeout_cnt <= '0;
      end else if ((state == HOLD) && !accept && (timeout_cnt != 4'd15)) begin
         timeout_cnt <= timeout_cnt + 4'd1;
      end
   end

   assign timeout_hit = (state == HOLD) && (timeout_cnt == 4'd15);
`else
   assign timeout_hit = 1'b0;
`endif

   // Command storage; a push into a full FIFO reuses the slot being popped
   always_ff @(posedge clock) begin
      if (enq) begin
         fifo_mem[wr_ptr] <= enq_cmd;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) begin
            wr_ptr <= PW'(wr_ptr + PW'(1));
         end
         if (deq) begin
            rd_ptr <= PW'(rd_ptr + PW'(1));
         end
         case ({enq, deq})
            2'b10:   count <= CW'(count + CW'(1));
            2'b01:   count <= CW'(count - CW'(1));
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         writes_done <= '0;
      end else if (deq) begin
         writes_done <= 16'(writes_done + 16'd1);
      end
   end

   assign head           = fifo_mem[rd_ptr];
   assign mem_write      = !fifo_empty;
   assign mem_address    = head.address;
   assign mem_writedata  = head.data;
   assign mem_byteenable = head.be;
   assign busy           = (state == HOLD) || !fifo_empty;

endmodule

// File: tb/tb_tile_result_writer.sv
// Self-checking bench for tile_result_writer: directed scenarios plus a randomized pixel stream
// scored against a stream-level packing model.
module tb_tile_result_writer;

   localparam logic [31:0] BASE = 32'h0000_1000;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
   } wr_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] in_addr = '0;
   logic [15:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        flush = 1'b0;
   logic [31:0] mem_address;
   logic [31:0] mem_writedata;
   logic [3:0]  mem_byteenable;
   logic        mem_write;
   logic        mem_waitrequest = 1'b0;
   logic        busy;
   logic [15:0] writes_done;

   int  checks = 0;
   int  errors = 0;
   wr_t exp_q[$];
   bit  stall_valid = 0;
   wr_t stall_cmd, got, exp_w;

   tile_result_writer #(.BASE_ADDR(BASE), .FIFO_DEPTH_BITS(3)) dut (
      .clock(clock), .reset(reset),
      .in_addr(in_addr), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .flush(flush),
      .mem_address(mem_address), .mem_writedata(mem_writedata),
      .mem_byteenable(mem_byteenable), .mem_write(mem_write),
      .mem_waitrequest(mem_waitrequest),
      .busy(busy), .writes_done(writes_done)
   );

   always #5 clock = ~clock;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [31:0] waddr(input logic [31:0] p);
      return BASE + ((p >> 1) << 2);
   endfunction

   // Memory-side scoreboard: completed writes in order, head stable while stalled
   always begin
      @(negedge clock);
      #2;
      if (reset) begin
         stall_valid = 0;
      end else begin
         got = '{mem_address, mem_writedata, mem_byteenable};
         if (stall_valid && mem_write) begin
            checks++;
            if (got !== stall_cmd) begin
               errors++;
               $display("FAIL stable_head: got %h/%h/%b required %h/%h/%b",
                        got.a, got.d, got.be, stall_cmd.a, stall_cmd.d, stall_cmd.be);
            end
         end
         stall_valid = 0;
         if (mem_write && mem_waitrequest) begin
            stall_valid = 1;
            stall_cmd   = got;
         end
         if (mem_write && !mem_waitrequest) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: got %h/%h/%b required none", got.a, got.d, got.be);
            end else begin
               exp_w = exp_q.pop_front();
               if (got !== exp_w) begin
                  errors++;
                  $display("FAIL write_order: got %h/%h/%b required %h/%h/%b",
                           got.a, got.d, got.be, exp_w.a, exp_w.d, exp_w.be);
               end
            end
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic [15:0] d, output int waited);
      waited = 0;
      in_addr = a; in_data = d; in_valid = 1'b1;
      #1;
      while (!in_ready && waited < 300) begin
         @(negedge clock); #1;
         waited++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout: pixel %h not accepted, in_ready %b required 1", a, in_ready);
      end
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 500) begin
         @(negedge clock); #1;
         n++;
      end
      checks++;
      if (busy || exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: busy %b pending %0d required 0 0", busy, exp_q.size());
      end
      @(negedge clock);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      reset = 1'b0;
      #1;
      checks += 4;
      if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b required 0", mem_write); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
      if (writes_done !== 16'd0) begin errors++; $display("FAIL reset_writes_done: got %0d required 0", writes_done); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
      @(negedge clock);
   endtask

   task automatic test_pair();
      int w;
      exp_q.push_back('{32'h0000_1008, 32'h0022_0011, 4'b1111});
      send(32'd4, 16'h0011, w);
      send(32'd5, 16'h0022, w);
      #1;
      checks += 2;
      if (mem_write !== 1'b1) begin errors++; $display("FAIL pair_latency: mem_write %b required 1", mem_write); end
      if (mem_address !== 32'h0000_1008) begin errors++; $display("FAIL pair_addr: got %h required 00001008", mem_address); end
      wait_drain();
      checks++;
      if (writes_done !== 16'd1) begin errors++; $display("FAIL pair_count: got %0d required 1", writes_done); end
   endtask

   task automatic test_odd();
      int w;
      exp_q.push_back('{BASE + 32'h0C, 32'hBEEF_0000, 4'b1100});
      send(32'd7, 16'hBEEF, w);
      #1;
      checks += 3;
      if (mem_write !== 1'b1) begin errors++; $display("FAIL odd_latency: mem_write %b required 1", mem_write); end
      if (mem_writedata !== 32'hBEEF_0000) begin errors++; $display("FAIL odd_data: got %h required beef0000", mem_writedata); end
      if (mem_byteenable !== 4'b1100) begin errors++; $display("FAIL odd_be: got %b required 1100", mem_byteenable); end
      wait_drain();
   endtask

   task automatic test_mismatch();
      int w;
      exp_q.push_back('{BASE + 32'h04, 32'h0000_00AA, 4'b0011});
      exp_q.push_back('{BASE + 32'h10, 32'h5A5A_0000, 4'b1100});
      send(32'd2, 16'h00AA, w);
      in_addr = 32'd9; in_data = 16'h5A5A; in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL mismatch_stall: in_ready %b required 0", in_ready); end
      @(negedge clock);
      send(32'd9, 16'h5A5A, w);
      checks++;
      if (w != 0) begin errors++; $display("FAIL mismatch_recover: waited %0d cycles required 0", w); end
      wait_drain();
   endtask

   task automatic test_backpressure();
      logic [31:0] pix[10];
      logic [15:0] dat[10];
      logic [15:0] wd0;
      int k = 0;
      int w;
      wd0 = writes_done;
      for (int i = 0; i < 10; i++) begin
         pix[i] = 32'd41 + 32'(2 * i);
         dat[i] = 16'($urandom);
         exp_q.push_back('{waddr(pix[i]), {dat[i], 16'h0000}, 4'b1100});
      end
      mem_waitrequest = 1'b1;
      for (int c = 0; c < 20; c++) begin
         in_addr = pix[k]; in_data = dat[k]; in_valid = 1'b1;
         #1;
         if (in_ready) k++;
         @(negedge clock);
      end
      in_addr = pix[k]; in_data = dat[k]; in_valid = 1'b1;
      #1;
      checks += 2;
      if (k != 8) begin errors++; $display("FAIL bp_accepted: got %0d required 8", k); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
      @(negedge clock);
      in_valid = 1'b0;
      mem_waitrequest = 1'b0;
      for (int i = k; i < 10; i++) send(pix[i], dat[i], w);
      wait_drain();
      checks++;
      if (writes_done !== 16'(wd0 + 16'd10)) begin
         errors++; $display("FAIL bp_count: got %0d required %0d", writes_done, 16'(wd0 + 16'd10));
      end
   endtask

   task automatic test_flush();
      logic [15:0] wd0;
      int w;
      wd0 = writes_done;
      send(32'd6, 16'h1234, w);
      repeat (5) @(negedge clock);
      #1;
      checks += 2;
      if (busy !== 1'b1) begin errors++; $display("FAIL flush_hold_busy: got %b required 1", busy); end
      if (mem_write !== 1'b0) begin errors++; $display("FAIL flush_hold_write: got %b required 0", mem_write); end
      @(negedge clock);
      exp_q.push_back('{BASE + 32'h0C, 32'h0000_1234, 4'b0011});
      pulse_flush();
      wait_drain();
      checks += 2;
      if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b required 0", busy); end
      if (writes_done !== 16'(wd0 + 16'd1)) begin errors++; $display("FAIL flush_count: got %0d required %0d", writes_done, 16'(wd0 + 16'd1)); end
      pulse_flush();
      repeat (4) @(negedge clock);
      #1;
      checks += 2;
      if (busy !== 1'b0) begin errors++; $display("FAIL flush_empty_busy: got %b required 0", busy); end
      if (writes_done !== 16'(wd0 + 16'd1)) begin errors++; $display("FAIL flush_empty_count: got %0d required %0d", writes_done, 16'(wd0 + 16'd1)); end
      @(negedge clock);
   endtask

   task automatic test_hold_idle();
      int w;
      int n = 0;
      send(32'd8, 16'h7777, w);
`ifdef TILE_WRITER_TIMEOUT_EN
      exp_q.push_back('{BASE + 32'h10, 32'h0000_7777, 4'b0011});
      #1;
      while (!mem_write && n < 40) begin
         @(negedge clock); #1;
         n++;
      end
      checks++;
      if (n != 16) begin errors++; $display("FAIL timeout_latency: write after %0d cycles required 16", n); end
      @(negedge clock);
`else
      repeat (40) @(negedge clock);
      #1;
      checks += 2;
      if (busy !== 1'b1) begin errors++; $display("FAIL hold_persist_busy: got %b required 1", busy); end
      if (mem_write !== 1'b0) begin errors++; $display("FAIL hold_persist_write: got %b required 0", mem_write); end
      @(negedge clock);
      exp_q.push_back('{BASE + 32'h10, 32'h0000_7777, 4'b0011});
      pulse_flush();
`endif
      wait_drain();
   endtask

   task automatic test_random_stream();
      localparam int N = 80;
      logic [31:0] pix[N];
      logic [15:0] dat[N];
      logic [15:0] wd0;
      bit          held = 0;
      logic [31:0] hp;
      logic [15:0] hd;
      int          nexp = 0;
      bit          done = 0;
      int          w;
      wd0 = writes_done;
      for (int i = 0; i < N; i++) begin
         if (i == 0 || ($urandom % 3) == 0) begin
            pix[i] = $urandom;
            if ($urandom % 2) pix[i][0] = 1'b0;
         end else begin
            pix[i] = pix[i-1] + 32'd1;
         end
         dat[i] = 16'($urandom);
      end
      // Stream-level packing rules: adjacent even/odd pair shares a word, otherwise halves go alone
      for (int i = 0; i < N; i++) begin
         if (held && pix[i] == hp + 32'd1) begin
            exp_q.push_back('{waddr(hp), {dat[i], hd}, 4'b1111});
            nexp++; held = 0;
            continue;
         end
         if (held) begin
            exp_q.push_back('{waddr(hp), {16'h0000, hd}, 4'b0011});
            nexp++; held = 0;
         end
         if (pix[i][0]) begin
            exp_q.push_back('{waddr(pix[i]), {dat[i], 16'h0000}, 4'b1100});
            nexp++;
         end else begin
            held = 1; hp = pix[i]; hd = dat[i];
         end
      end
      if (held) begin
         exp_q.push_back('{waddr(hp), {16'h0000, hd}, 4'b0011});
         nexp++;
      end
      fork
         begin
            for (int i = 0; i < N; i++) begin
               if ($urandom % 2) repeat ($urandom_range(1, 2)) @(negedge clock);
               send(pix[i], dat[i], w);
            end
            done = 1;
         end
         begin
            while (!done) begin
               @(negedge clock);
               mem_waitrequest = (($urandom % 4) == 0);
            end
         end
      join
      mem_waitrequest = 1'b0;
      pulse_flush();
      wait_drain();
      checks++;
      if (writes_done !== 16'(wd0 + 16'(nexp))) begin
         errors++; $display("FAIL random_count: got %0d required %0d", writes_done, 16'(wd0 + 16'(nexp)));
      end
   endtask

   task automatic test_reset_mid();
      int w;
      int n = 0;
      mem_waitrequest = 1'b1;
      send(32'd3, 16'hCAFE, w);
      #1;
      while (!mem_write && n < 10) begin @(negedge clock); #1; n++; end
      checks++;
      if (mem_write !== 1'b1) begin errors++; $display("FAIL rstmid_pending: mem_write %b required 1", mem_write); end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      #1;
      checks += 3;
      if (mem_write !== 1'b0) begin errors++; $display("FAIL rstmid_mem_write: got %b required 0", mem_write); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b required 0", busy); end
      if (writes_done !== 16'd0) begin errors++; $display("FAIL rstmid_count: got %0d required 0", writes_done); end
      @(negedge clock);
      reset = 1'b0;
      mem_waitrequest = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clock);
      #1;
      checks++;
      if (mem_write !== 1'b0) begin errors++; $display("FAIL rstmid_dropped: mem_write %b required 0", mem_write); end
   endtask

   initial begin
      test_reset();
      test_pair();
      test_odd();
      test_mismatch();
      test_backpressure();
      test_flush();
      test_hold_idle();
      test_random_stream();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tile_result_writer.md
TILE_RESULT_WRITER -- requirements
Module: tile_result_writer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte base address of the result buffer; SHALL be 4-byte aligned.
REQ-002 Parameter FIFO_DEPTH_BITS, default 3: write-command FIFO holds 2**FIFO_DEPTH_BITS entries.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 in_addr  input  32  pixel index, one 16-bit halfword per index, from the tile solver.
REQ-006 in_data  input  16  iteration count for that pixel.
REQ-007 in_valid  input  1  in_addr/in_data valid.
REQ-008 in_ready  output  1  block accepts the pixel this cycle.
REQ-009 flush  input  1  single-cycle pulse; force out any held halfword.
REQ-010 mem_address  output  32  word-aligned byte address.
REQ-011 mem_writedata  output  32  write data.
REQ-012 mem_byteenable  output  4  byte lanes.
REQ-013 mem_write  output  1  write request.
REQ-014 mem_waitrequest  input  1  memory stall.
REQ-015 busy  output  1  high while a halfword is held or the FIFO is non-empty.
REQ-016 writes_done  output  16  count of completed memory writes, wraps at 16'hFFFF -> 0.

Function
REQ-017 Handshake: a pixel transfers on a cycle with in_valid && in_ready; a write completes on a cycle with mem_write && !mem_waitrequest.
REQ-018 Word address for pixel p: BASE_ADDR + {p[31:1], 2'b00}; even p -> lanes [15:0], odd p -> lanes [31:16].
REQ-019 Pack FSM states: EMPTY and HOLD (one even-addressed pixel stored in a pack register).
REQ-020 EMPTY, odd pixel accepted: enqueue {data,16'h0}, BE 4'b1100; stay EMPTY.
REQ-021 EMPTY, even pixel accepted: store it; go to HOLD; nothing enqueued.
REQ-022 HOLD, pixel accepted with addr == held_addr+1: enqueue {in_data,held_data}, BE 4'b1111; go to EMPTY.
REQ-023 HOLD, in_valid with any other addr: in_ready=0; enqueue {16'h0,held_data}, BE 4'b0011; go to EMPTY; the new pixel is handled on a following cycle under REQ-020/021.
REQ-024 HOLD, flush=1 and no pixel accepted: enqueue held halfword as in REQ-023; go to EMPTY. flush in EMPTY: no effect.
REQ-025 Simultaneous flush and matching pixel in HOLD: the combine of REQ-022 wins; flush is consumed.
REQ-026 in_ready=1 only if the FIFO is not full and REQ-023 does not apply; any enqueue requires a free FIFO entry, else the FSM waits in its current state.
REQ-027 FIFO is show-ahead: mem_write=1 whenever non-empty; mem_address/mem_writedata/mem_byteenable reflect the head entry and SHALL stay stable while mem_waitrequest=1.
REQ-028 Latency: an entry enqueued at the edge ending cycle N is visible on mem_* in cycle N+1 when the FIFO was empty.
REQ-029 Enqueue and dequeue in the same cycle SHALL be supported when full; occupancy unchanged, no data lost.
REQ-030 Write order on the memory port SHALL equal enqueue order.
REQ-031 writes_done increments by 1 on each completed write.

Reset
REQ-032 On reset: FSM=EMPTY, FIFO empty, held halfword discarded, writes_done=0, mem_write=0, busy=0; in_ready=1 in the first cycle after reset.
REQ-033 Reset mid-transfer SHALL drop the outstanding write, even with mem_waitrequest=1; the interconnect tolerates this.

Configuration
REQ-034 Macro TILE_WRITER_TIMEOUT_EN: when defined, a 4-bit counter clears on entry to HOLD and increments each HOLD cycle without an accepted pixel; at 15 the held halfword is enqueued as in REQ-024.
REQ-035 Without TILE_WRITER_TIMEOUT_EN, HOLD is left only via REQ-022/023/024 or reset.

Verification
REQ-036 Pixels 4 (0x0011), then 5 (0x0022), BASE_ADDR 0x1000, no stall -> one write: addr 0x1008, data 0x0022_0011, BE 1111; writes_done=1.
REQ-037 Pixel 7 (0xBEEF) -> write addr BASE+0x0C, data 0xBEEF_0000, BE 1100 one cycle after acceptance.
REQ-038 Pixel 2 (0x00AA) then pixel 9 -> in_ready low one cycle; writes: BASE+0x04 data 0x0000_00AA BE 0011, then BASE+0x10 BE 1100.
REQ-039 mem_waitrequest held high, 10 odd pixels offered, depth 8 -> exactly 8 accepted, in_ready=0; release -> 8 writes in order with stable outputs, then remaining 2 accepted.
REQ-040 Pixel 6 held, no further input: flush pulse -> BE 0011 write; with TILE_WRITER_TIMEOUT_EN and no flush -> same write after 15 HOLD cycles; busy falls after completion.
REQ-041 Reset asserted while mem_write=1 and mem_waitrequest=1 -> next cycle mem_write=0, busy=0, writes_done=0.
